// File: rtl/pbkdf2_pkg.sv
// Shared types and widths for the PBKDF2-HMAC-SHA256 iteration controller.
package pbkdf2_pkg;
  localparam int KEY_W          = 512;
  localparam int MSG_W          = 440;
  localparam int PRF_W          = 256;
  localparam int LEN_W          = 5;
  localparam int U_LEN_WORDS    = 8;
  localparam int MAX_SALT_WORDS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/pbkdf2_msg_fmt.sv
// Builds the HMAC message: first iteration is S || INT(i), later ones carry U(j-1).
module pbkdf2_msg_fmt
  import pbkdf2_pkg::*;
#(
  parameter int SALT_W = 384
) (
  input  logic [SALT_W-1:0] salt_i,
  input  logic [3:0]        salt_len_i,
  input  logic [31:0]       blk_idx_i,
  input  logic [PRF_W-1:0]  u_i,
  input  logic              first_i,
  output logic [MSG_W-1:0]  msg_o,
  output logic [LEN_W-1:0]  len_o
);
  localparam int SALT_WORDS = SALT_W / 32;

  logic [MSG_W-1:0] idx_part;

  // salt_len_i arrives already clamped to at most SALT_WORDS
  assign idx_part = {blk_idx_i, {(MSG_W-32){1'b0}}} >> {salt_len_i, 5'b0};

  always_comb begin
    msg_o = '0;
    len_o = LEN_W'(U_LEN_WORDS);
    if (first_i) begin
      for (int w = 0; w < SALT_WORDS; w++) begin
        if (w < int'(salt_len_i)) begin
          msg_o[MSG_W-1-32*w -: 32] = salt_i[SALT_W-1-32*w -: 32];
        end
      end
      msg_o = msg_o | idx_part;
      len_o = LEN_W'(salt_len_i) + LEN_W'(1);
    end else begin
      msg_o = {u_i, {(MSG_W-PRF_W){1'b0}}};
    end
  end
endmodule

// File: rtl/pbkdf2_f_block.sv
// PBKDF2 F-function controller: runs c HMAC iterations and XOR-accumulates T_i.
module pbkdf2_f_block
  import pbkdf2_pkg::*;
#(
  parameter int ITER_W = 32,
  parameter int SALT_W = 384
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              v_i,
  output logic              r_o,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [SALT_W-1:0] salt_i,
  input  logic [3:0]        salt_len_i,
  input  logic [31:0]       blk_idx_i,
  input  logic [ITER_W-1:0] iter_i,
  output logic [PRF_W-1:0]  t_o,
  output logic              v_o,
  input  logic              r_i,
  output logic [KEY_W-1:0]  hmac_key_o,
  output logic [MSG_W-1:0]  hmac_msg_o,
  output logic [LEN_W-1:0]  hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [PRF_W-1:0]  hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o,
  output state_e            state_o
);
  // All four handshakes transfer on a clock edge where valid and ready are both
  // high; a valid, once raised, holds itself and its payload until that edge.
  state_e              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [ITER_W-1:0]   iter_q;
  logic [KEY_W-1:0]    key_q;
  logic [SALT_W-1:0]   salt_q;
  logic [3:0]          salt_len_q;
  logic [31:0]         idx_q;
  logic [PRF_W-1:0]    u_q;
  logic [PRF_W-1:0]    t_q;
  logic                load;
  logic                consume;
  logic                first;

  assign first = (cnt_q == ITER_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          load    = 1'b1;
          cnt_d   = ITER_W'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (hmac_r_i) state_d = WAIT;
      end
      WAIT: begin
        if (hmac_v_i) begin
          consume = 1'b1;
          if (cnt_q == iter_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ITER_W'(1);
            state_d = SEND;
          end
        end
      end
      DONE: begin
        if (r_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      iter_q     <= '0;
      key_q      <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
      idx_q      <= '0;
      u_q        <= '0;
      t_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        key_q      <= key_i;
        salt_q     <= salt_i;
        salt_len_q <= (salt_len_i > 4'(MAX_SALT_WORDS)) ? 4'(MAX_SALT_WORDS) : salt_len_i;
        idx_q      <= blk_idx_i;
        // a zero iteration count would never match the counter, so run it once
        iter_q     <= (iter_i == '0) ? ITER_W'(1) : iter_i;
      end
      if (consume) begin
        u_q <= hmac_prf_i;
        t_q <= first ? hmac_prf_i : (t_q ^ hmac_prf_i);
      end
    end
  end

  pbkdf2_msg_fmt #(
    .SALT_W(SALT_W)
  ) u_msg_fmt (
    .salt_i    (salt_q),
    .salt_len_i(salt_len_q),
    .blk_idx_i (idx_q),
    .u_i       (u_q),
    .first_i   (first),
    .msg_o     (hmac_msg_o),
    .len_o     (hmac_len_o)
  );

  assign r_o        = rst_i && (state_q == IDLE);
  assign v_o        = (state_q == DONE);
  assign t_o        = t_q;
  assign hmac_v_o   = (state_q == SEND);
  assign hmac_r_o   = (state_q == WAIT);
  assign hmac_key_o = key_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_pbkdf2_f_block.sv
// Bench for pbkdf2_f_block: stub HMAC (prf = msg[439:184] ^ 1) plus result scoreboard.
module tb_pbkdf2_f_block;
  import pbkdf2_pkg::*;

  localparam int ITER_W   = 32;
  localparam int SALT_W   = 384;
  localparam int HMAC_LAT = 10;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              v_i = 1'b0;
  logic              r_o;
  logic [KEY_W-1:0]  key_i = '0;
  logic [SALT_W-1:0] salt_i = '0;
  logic [3:0]        salt_len_i = '0;
  logic [31:0]       blk_idx_i = '0;
  logic [ITER_W-1:0] iter_i = '0;
  logic [PRF_W-1:0]  t_o;
  logic              v_o;
  logic              r_i = 1'b0;
  logic [KEY_W-1:0]  hmac_key_o;
  logic [MSG_W-1:0]  hmac_msg_o;
  logic [LEN_W-1:0]  hmac_len_o;
  logic              hmac_v_o;
  logic              hmac_r_i = 1'b0;
  logic [PRF_W-1:0]  hmac_prf_i = '0;
  logic              hmac_v_i = 1'b0;
  logic              hmac_r_o;
  state_e            state_dbg;

  pbkdf2_f_block #(.ITER_W(ITER_W), .SALT_W(SALT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .v_i(v_i), .r_o(r_o), .key_i(key_i),
    .salt_i(salt_i), .salt_len_i(salt_len_i), .blk_idx_i(blk_idx_i),
    .iter_i(iter_i), .t_o(t_o), .v_o(v_o), .r_i(r_i),
    .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o), .hmac_len_o(hmac_len_o),
    .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i), .hmac_prf_i(hmac_prf_i),
    .hmac_v_i(hmac_v_i), .hmac_r_o(hmac_r_o), .state_o(state_dbg)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PRF_W-1:0] exp_q[$];
  logic [MSG_W-1:0] msg_exp_q[$];
  logic [LEN_W-1:0] len_exp_q[$];
  logic [KEY_W-1:0] cur_key = '0;
  int req_delay = 0;
  int out_delay = 0;
  int hs_count  = 0;

  task automatic check(input string name, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // HMAC stub: request side with optional backpressure, response after HMAC_LAT cycles
  int               wait_cnt = 0;
  int               lat_cnt = 0;
  bit               pend = 0;
  bit               req_hold = 0;
  logic [MSG_W-1:0] prev_msg;
  logic [LEN_W-1:0] prev_len;
  logic [PRF_W-1:0] prf_hold;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      hmac_r_i = 1'b0; hmac_v_i = 1'b0; pend = 0; wait_cnt = 0; lat_cnt = 0; req_hold = 0;
    end else begin
      hmac_v_i   = 1'b0;
      hmac_prf_i = {8{$urandom()}};
      if (pend) begin
        if (lat_cnt > 0) lat_cnt--;
        else begin
          hmac_v_i   = 1'b1;
          hmac_prf_i = prf_hold;
          if (hmac_r_o) pend = 0;
        end
      end
      if (req_hold) begin
        check("req_v_stable", KEY_W'(hmac_v_o), KEY_W'(1'b1));
        check("req_msg_stable", KEY_W'(hmac_msg_o), KEY_W'(prev_msg));
        check("req_len_stable", KEY_W'(hmac_len_o), KEY_W'(prev_len));
      end
      req_hold = 0;
      hmac_r_i = 1'b0;
      if (hmac_v_o) begin
        if (wait_cnt < req_delay) begin
          wait_cnt++;
          req_hold = 1;
          prev_msg = hmac_msg_o;
          prev_len = hmac_len_o;
        end else begin
          hmac_r_i = 1'b1;
          wait_cnt = 0;
          hs_count++;
          if (msg_exp_q.size() == 0) fail_now("unexpected_hmac_request");
          else begin
            check("req_msg", KEY_W'(hmac_msg_o), KEY_W'(msg_exp_q.pop_front()));
            check("req_len", KEY_W'(hmac_len_o), KEY_W'(len_exp_q.pop_front()));
            check("req_key", hmac_key_o, cur_key);
          end
          pend     = 1;
          lat_cnt  = HMAC_LAT;
          prf_hold = hmac_msg_o[MSG_W-1 -: PRF_W] ^ PRF_W'(1);
        end
      end
    end
  end

  // result monitor / scoreboard
  int               out_wait = 0;
  bit               out_hold = 0;
  logic [PRF_W-1:0] prev_t;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      r_i = 1'b0; out_wait = 0; out_hold = 0;
    end else begin
      if (out_hold) begin
        check("v_o_stable", KEY_W'(v_o), KEY_W'(1'b1));
        check("t_o_stable", KEY_W'(t_o), KEY_W'(prev_t));
      end
      out_hold = 0;
      r_i = 1'($urandom_range(0, 1));
      if (v_o) begin
        r_i = 1'b0;
        if (out_wait < out_delay) begin
          out_wait++;
          out_hold = 1;
          prev_t = t_o;
        end else begin
          r_i = 1'b1;
          out_wait = 0;
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else check("t_o", KEY_W'(t_o), KEY_W'(exp_q.pop_front()));
        end
      end
    end
  end

  // reference model of one F-block job under the stub PRF
  task automatic expect_job(input logic [SALT_W-1:0] salt, input int len, input logic [31:0] idx, input longint iter);
    int               l;
    longint           c;
    logic [MSG_W-1:0] m;
    logic [MSG_W-1:0] mask;
    logic [PRF_W-1:0] u, t;
    l = (len > 12) ? 12 : len;
    c = (iter == 0) ? 1 : iter;
    mask = ~({MSG_W{1'b1}} >> (32 * l));
    m = ({salt, 56'b0} & mask) | ({idx, 408'b0} >> (32 * l));
    msg_exp_q.push_back(m);
    len_exp_q.push_back(LEN_W'(l + 1));
    u = m[MSG_W-1 -: PRF_W] ^ PRF_W'(1);
    t = u;
    for (longint j = 2; j <= c; j++) begin
      m = {u, 184'b0};
      msg_exp_q.push_back(m);
      len_exp_q.push_back(LEN_W'(8));
      u = m[MSG_W-1 -: PRF_W] ^ PRF_W'(1);
      t = t ^ u;
    end
    exp_q.push_back(t);
  endtask

  // driver tasks
  task automatic issue(input logic [KEY_W-1:0] key, input logic [SALT_W-1:0] salt, input logic [3:0] len,
                       input logic [31:0] idx, input logic [ITER_W-1:0] iter);
    int guard = 0;
    @(negedge clk_i);
    while (!r_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!r_o) fail_now("accept_timeout");
    key_i = key; salt_i = salt; salt_len_i = len; blk_idx_i = idx; iter_i = iter;
    cur_key = key;
    hs_count = 0;
    v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    key_i = {16{$urandom()}};
    salt_i = {12{$urandom()}};
    salt_len_i = 4'($urandom_range(0, 15));
    blk_idx_i = $urandom();
    iter_i = $urandom();
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while (!(exp_q.size() == 0 && r_o) && guard < 3000);
    if (guard >= 3000) fail_now({name, "_timeout"});
  endtask

  localparam logic [KEY_W-1:0]  KEY_PW  = {64'h70617373776f7264, 448'b0};
  localparam logic [SALT_W-1:0] SALT_S  = {32'h73616c74, 352'b0};
  localparam logic [SALT_W-1:0] SALT_12 = 384'h01010101_02020202_03030303_04040404_05050505_06060606_07070707_08080808_09090909_0a0a0a0a_0b0b0b0b_0c0c0c0c;

  initial begin
    int guard;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_r_o", KEY_W'(r_o), '0);
    check("reset_v_o", KEY_W'(v_o), '0);
    check("reset_t_o", KEY_W'(t_o), '0);
    check("reset_hmac_v_o", KEY_W'(hmac_v_o), '0);
    check("reset_hmac_r_o", KEY_W'(hmac_r_o), '0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_r_o", KEY_W'(r_o), KEY_W'(1'b1));

    // single iteration, hand-computed message and result
    msg_exp_q.push_back({64'h73616c74_00000001, 376'b0});
    len_exp_q.push_back(LEN_W'(2));
    exp_q.push_back({64'h73616c74_00000001, 192'b0} ^ 256'h1);
    issue(KEY_PW, SALT_S, 4'd1, 32'd1, 32'd1);
    wait_idle("job_iter1");
    check("job_iter1_handshakes", KEY_W'(hs_count), KEY_W'(1));
    check("t_o_held_in_idle", KEY_W'(t_o), KEY_W'({64'h73616c74_00000001, 192'b0} ^ 256'h1));

    // three iterations
    expect_job(SALT_S, 1, 32'd1, 3);
    issue(KEY_PW, SALT_S, 4'd1, 32'd1, 32'd3);
    wait_idle("job_iter3");
    check("job_iter3_handshakes", KEY_W'(hs_count), KEY_W'(3));

    // backpressure on both sides, plus requests while busy
    req_delay = 5;
    out_delay = 7;
    expect_job({96'h0a0b0c0d_11223344_55667788, 288'b0}, 3, 32'd2, 2);
    issue({16{32'h5a5a1234}}, {96'h0a0b0c0d_11223344_55667788, 288'b0}, 4'd3, 32'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk_i);
      v_i = 1'b1;
      iter_i = 32'd1;
      check("busy_r_o", KEY_W'(r_o), '0);
      @(negedge clk_i);
      v_i = 1'b0;
    end
    wait_idle("job_backpressure");
    check("job_backpressure_handshakes", KEY_W'(hs_count), KEY_W'(2));
    req_delay = 0;
    out_delay = 0;

    // iter = 0 and salt_len = 15 behave as 1 and 12
    msg_exp_q.push_back({SALT_12, 32'hdeadbeef, 24'b0});
    len_exp_q.push_back(LEN_W'(13));
    exp_q.push_back(SALT_12[383:128] ^ 256'h1);
    issue(KEY_PW, SALT_12, 4'd15, 32'hdeadbeef, 32'd0);
    wait_idle("job_clamp");
    check("job_clamp_handshakes", KEY_W'(hs_count), KEY_W'(1));

    // empty salt, and a longer full-salt job
    expect_job(SALT_12, 0, 32'd5, 2);
    issue(KEY_PW, SALT_12, 4'd0, 32'd5, 32'd2);
    wait_idle("job_nosalt");
    expect_job(SALT_12, 12, 32'h00010002, 4);
    issue({16{32'hc001d00d}}, SALT_12, 4'd12, 32'h00010002, 32'd4);
    wait_idle("job_iter4");
    check("job_iter4_handshakes", KEY_W'(hs_count), KEY_W'(4));

    // asynchronous reset during WAIT of iteration 2
    expect_job(SALT_S, 1, 32'd1, 3);
    issue(KEY_PW, SALT_S, 4'd1, 32'd1, 32'd3);
    guard = 0;
    while (!(hs_count == 2 && hmac_r_o) && guard < 500) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 500) fail_now("reach_wait2_timeout");
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midreset_t_o", KEY_W'(t_o), '0);
    check("midreset_v_o", KEY_W'(v_o), '0);
    check("midreset_hmac_v_o", KEY_W'(hmac_v_o), '0);
    check("midreset_hmac_r_o", KEY_W'(hmac_r_o), '0);
    check("midreset_r_o", KEY_W'(r_o), '0);
    exp_q.delete();
    msg_exp_q.delete();
    len_exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("after_reset_r_o", KEY_W'(r_o), KEY_W'(1'b1));
    check("after_reset_v_o", KEY_W'(v_o), '0);
    expect_job(SALT_S, 1, 32'd1, 1);
    issue(KEY_PW, SALT_S, 4'd1, 32'd1, 32'd1);
    wait_idle("job_after_reset");
    check("job_after_reset_handshakes", KEY_W'(hs_count), KEY_W'(1));

    repeat (5) @(negedge clk_i);
    check("queues_drained", KEY_W'(exp_q.size() + msg_exp_q.size() + len_exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pbkdf2_f_block.md
Name: pbkdf2_f_block

Overview:
- Iteration controller for the PBKDF2-HMAC-SHA256 core.
- Computes one output block T_i = U1 ^ U2 ^ ... ^ Uc.
  - U1 = PRF(P, S || INT(i)).
  - Uj = PRF(P, U(j-1)).
- Sits directly upstream and downstream of hmac_sha256: drives its key/msg/valid inputs and consumes its prf/valid outputs, once per iteration.
- The top-level key-derivation wrapper sequences successive block indices through this block.

Parameters:
- ITER_W, 32, width of the iteration count.
- SALT_W, 384, salt field width (12 words, left aligned).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous assert, active-low (0 = reset).
- v_i  in  1  job request valid.
- r_o  out  1  ready for job (IDLE only).
- key_i  in  512  password, left aligned, zero filled.
- salt_i  in  SALT_W  salt, left aligned, zero filled.
- salt_len_i  in  4  salt length in 32-bit words, 0..12.
- blk_idx_i  in  32  block index i (big-endian INT(i)).
- iter_i  in  ITER_W  iteration count c.
- t_o  out  256  result T_i.
- v_o  out  1  result valid.
- r_i  in  1  downstream accepts result.
- hmac_key_o  out  512  to hmac key_i.
- hmac_msg_o  out  440  to hmac msg_i, left aligned.
- hmac_len_o  out  5  to hmac msg_len_i, in 32-bit words.
- hmac_v_o  out  1  to hmac v_i.
- hmac_r_i  in  1  from hmac r_o (request taken).
- hmac_prf_i  in  256  from hmac prf_o.
- hmac_v_i  in  1  from hmac v_o.
- hmac_r_o  out  1  to hmac r_i.

Behaviour:
- Reset (rst_i low, async):
  - State = IDLE; counter, U reg, T reg and latched inputs cleared.
  - t_o = 0, v_o = 0, hmac_v_o = 0, hmac_r_o = 0.
  - r_o = 0 while reset is asserted, 1 after deassertion.
  - Reset mid-job abandons the job; no partial result is presented.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - r_o = 1.
  - On v_i & r_o: latch key, salt, salt_len, blk_idx, iter; cnt <= 1; go to SEND.
  - iter_i == 0 is treated as 1.
  - salt_len_i > 12 is clamped to 12.
- SEND:
  - hmac_v_o = 1; hmac_key_o = latched key.
  - If cnt == 1:
    - msg = salt words [0..salt_len-1], then blk_idx in the following word, rest zero.
    - hmac_len_o = salt_len + 1.
  - Else:
    - msg = {U, 184'b0}; hmac_len_o = 8.
  - On hmac_r_i go to WAIT.
  - hmac_v_o stays high until hmac_r_i.
  - msg/key/len are stable for the whole time hmac_v_o is high.
- WAIT:
  - hmac_r_o = 1.
  - On hmac_v_i:
    - U <= prf.
    - T <= (cnt == 1) ? prf : T ^ prf.
    - If cnt == iter: go to DONE.
    - Else: cnt <= cnt + 1 and go to SEND.
  - Consume is a single cycle: hmac_v_i & hmac_r_o in the same cycle.
- DONE:
  - v_o = 1; t_o = T, held stable.
  - On r_i go to IDLE; r_o rises the next cycle.
  - New jobs are never accepted in DONE.
- t_o is registered; it holds the last T until the next job's first accumulate.
- Latency per iteration: 1 SEND cycle minimum, plus hmac latency, plus 1 consume cycle.
  - Total ≈ c × (hmac latency + 2) + 2 cycles from accept to v_o.
- Counter:
  - cnt compares against the latched iter; it never wraps.
  - iter = 2^ITER_W − 1 completes normally.
- Simultaneous events:
  - v_i while busy is ignored; r_o = 0.
  - r_i outside DONE has no effect.
  - hmac_v_i outside WAIT is ignored; hmac_r_o = 0.

Decomposition:
- pbkdf2_pkg holds:
  - The state enum.
  - Constants KEY_W = 512, MSG_W = 440, PRF_W = 256, LEN_W = 5, U_LEN_WORDS = 8.
- One combinational sub-module, pbkdf2_msg_fmt: builds hmac_msg_o/hmac_len_o from salt, salt_len, blk_idx, U and the first-iteration flag.

Test Plan:
- Stub HMAC (prf = msg[439:184] ^ 256'h1, 10-cycle latency); salt_len = 1, salt = 32'h73616c74, idx = 1, iter = 1:
  - hmac_msg_o = 64'h73616c74_00000001 followed by zeros; hmac_len_o = 2.
  - t_o = {64'h73616c74_00000001, 192'b0} ^ 1.
- Same stub, iter = 3:
  - Exactly 3 hmac_v_o/hmac_r_i handshakes.
  - 2nd and 3rd messages carry hmac_len_o = 8.
  - t_o = U1 ^ U2 ^ U3, checked against a bench model.
- Real hmac_sha256, key "password", salt "salt", idx = 1:
  - iter = 1: t_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b.
  - iter = 2: t_o = ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
- Backpressure: stub delays hmac_r_i 5 cycles and r_i 7 cycles.
  - hmac_v_o, hmac_msg_o and v_o/t_o stay stable throughout.
  - v_i pulses during the job are ignored.
- iter = 0 and salt_len = 15:
  - Behaves as iter = 1 and salt_len = 12.
  - hmac_len_o = 13; blk_idx lands at bits [55:24] of the 440-bit msg.
- rst_i pulsed low in WAIT of iteration 2:
  - Outputs are zero immediately (async).
  - After release: r_o = 1, v_o = 0.
  - A fresh iter = 1 job then produces the correct t_o.
